// File: rtl/grid_io_cfg_bank.sv
// grid_io_cfg_bank: per-channel IO configuration bank with shadow/active
// double buffering, pad drive/enable mapping and a 2-flop input synchroniser.
// Optional feature: define GRID_IO_READBACK_EN to add a registered
// configuration readback port (rd_en/rd_addr/rd_sel -> rd_data/rd_valid).
module grid_io_cfg_bank #(
    parameter int NUM_IO = 8,
    parameter int CFG_W  = 2,
    localparam int ADDR_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [CFG_W-1:0]  data_in,
    input  logic              commit,
    input  logic              clr_err,
`ifdef GRID_IO_READBACK_EN
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_sel,
    output logic [CFG_W-1:0]  rd_data,
    output logic              rd_valid,
`endif
    input  logic [NUM_IO-1:0] io_outpad,
    input  logic [NUM_IO-1:0] pad_in,
    output logic [NUM_IO-1:0] pad_out,
    output logic [NUM_IO-1:0] pad_oe,
    output logic [NUM_IO-1:0] io_inpad,
    output logic              cfg_dirty,
    output logic              addr_err
);

    // One extra bit so NUM_IO itself is representable for the range check.
    localparam logic [ADDR_W:0] NUM_IO_LIM = (ADDR_W + 1)'(NUM_IO);
    localparam bit              HAS_INV    = (CFG_W >= 2);
    localparam int              INV_BIT    = (CFG_W >= 2) ? 1 : 0;

    logic [CFG_W-1:0]  shadow [NUM_IO];
    logic [CFG_W-1:0]  active [NUM_IO];
    logic [NUM_IO-1:0] sync_1;
    logic [NUM_IO-1:0] sync_2;
    logic              write_legal;
    logic              write_illegal;
    logic [NUM_IO-1:0] write_hit;

    // Decode the write strobe into legal/illegal and a one-hot channel hit.
    always_comb begin
        write_legal   = enable && ({1'b0, address} < NUM_IO_LIM);
        write_illegal = enable && !({1'b0, address} < NUM_IO_LIM);
        for (int i = 0; i < NUM_IO; i++) begin
            write_hit[i] = write_legal && (address == ADDR_W'(i));
        end
    end

    // Shadow takes writes; commit copies shadow to active, with the write bypassing.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            for (int i = 0; i < NUM_IO; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IO; i++) begin
                if (write_hit[i]) begin
                    shadow[i] <= data_in;
                end
                if (commit) begin
                    active[i] <= write_hit[i] ? data_in : shadow[i];
                end
            end
        end
    end

    // Dirty tracks uncommitted writes; addr_err is sticky, set wins over clear.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            cfg_dirty <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (commit) begin
                cfg_dirty <= 1'b0;
            end else if (write_legal) begin
                cfg_dirty <= 1'b1;
            end
            if (write_illegal) begin
                addr_err <= 1'b1;
            end else if (clr_err) begin
                addr_err <= 1'b0;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= pad_in;
            sync_2 <= sync_1;
        end
    end

    // Pad mapping: bit0 enables the driver, bit1 inverts the input, driven pads read 0.
    always_comb begin
        pad_out  = io_outpad;
        pad_oe   = '0;
        io_inpad = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            pad_oe[i]   = active[i][0];
            io_inpad[i] = active[i][0] ? 1'b0
                        : (sync_2[i] ^ (HAS_INV && active[i][INV_BIT]));
        end
    end

`ifdef GRID_IO_READBACK_EN
    logic [CFG_W-1:0] rd_word;

    // Select the addressed bank word; out-of-range addresses match nothing and read 0.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = rd_sel ? active[i] : shadow[i];
            end
        end
    end

    // Register the readback so it shows pre-edge contents one cycle after rd_en.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// tb_grid_io_cfg_bank: scoreboard bench for grid_io_cfg_bank (NUM_IO=6, CFG_W=2).
// The driver updates a behavioural model each cycle and queues the expected
// outputs; a monitor pops and compares them one step after each rising edge.
module tb_grid_io_cfg_bank;

    localparam int NUM_IO = 6;
    localparam int CFG_W  = 2;
    localparam int ADDR_W = 3;

    logic              prog_clk  = 1'b0;
    logic              pReset_n  = 1'b0;
    logic              enable    = 1'b0;
    logic [ADDR_W-1:0] address   = '0;
    logic [CFG_W-1:0]  data_in   = '0;
    logic              commit    = 1'b0;
    logic              clr_err   = 1'b0;
    logic [NUM_IO-1:0] io_outpad = '0;
    logic [NUM_IO-1:0] pad_in    = '0;
    logic [NUM_IO-1:0] pad_out;
    logic [NUM_IO-1:0] pad_oe;
    logic [NUM_IO-1:0] io_inpad;
    logic              cfg_dirty;
    logic              addr_err;
`ifdef GRID_IO_READBACK_EN
    logic              rd_en   = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_sel  = 1'b0;
    logic [CFG_W-1:0]  rd_data;
    logic              rd_valid;
`endif

    grid_io_cfg_bank #(.NUM_IO(NUM_IO), .CFG_W(CFG_W)) dut (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .enable    (enable),
        .address   (address),
        .data_in   (data_in),
        .commit    (commit),
        .clr_err   (clr_err),
`ifdef GRID_IO_READBACK_EN
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
`endif
        .io_outpad (io_outpad),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .io_inpad  (io_inpad),
        .cfg_dirty (cfg_dirty),
        .addr_err  (addr_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic [NUM_IO-1:0] oe;
        logic [NUM_IO-1:0] out;
        logic [NUM_IO-1:0] inpad;
        logic              dirty;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    int                vectors     = 0;
    int                miscompares = 0;

    // Behavioural model: bank contents, flags and a pad_in sample history.
    logic [CFG_W-1:0]  m_shadow [NUM_IO];
    logic [CFG_W-1:0]  m_active [NUM_IO];
    logic              m_dirty;
    logic              m_err;
    logic [NUM_IO-1:0] m_pin_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_IO; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_dirty = 1'b0;
        m_err   = 1'b0;
        m_pin_q = {6'h00, 6'h00};
    endfunction

    // One clock edge of the rules: write to shadow, commit publishes the
    // post-write shadow (so a same-cycle write lands in active too).
    function automatic void model_edge(input logic en, input logic [ADDR_W-1:0] addr,
                                       input logic [CFG_W-1:0] din, input logic com,
                                       input logic clr, input logic [NUM_IO-1:0] pin);
        bit legal;
        legal = en && (int'(addr) < NUM_IO);
        if (legal) m_shadow[addr] = din;
        if (com) begin
            for (int i = 0; i < NUM_IO; i++) m_active[i] = m_shadow[i];
            m_dirty = 1'b0;
        end else if (legal) begin
            m_dirty = 1'b1;
        end
        if (en && !legal) m_err = 1'b1;
        else if (clr)     m_err = 1'b0;
        m_pin_q.push_back(pin);
        void'(m_pin_q.pop_front());
    endfunction

    function automatic exp_t model_outputs(input logic [NUM_IO-1:0] outpad);
        exp_t e;
        logic [NUM_IO-1:0] delayed;
        delayed = m_pin_q[0];
        e.out   = outpad;
        e.dirty = m_dirty;
        e.err   = m_err;
        for (int i = 0; i < NUM_IO; i++) begin
            e.oe[i]    = m_active[i][0];
            e.inpad[i] = m_active[i][0] ? 1'b0 : (delayed[i] ^ m_active[i][1]);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic en, input logic [ADDR_W-1:0] addr,
                                 input logic [CFG_W-1:0] din, input logic com,
                                 input logic clr, input logic [NUM_IO-1:0] outpad,
                                 input logic [NUM_IO-1:0] pin);
        @(negedge prog_clk);
        pReset_n  = 1'b1;
        enable    = en;
        address   = addr;
        data_in   = din;
        commit    = com;
        clr_err   = clr;
        io_outpad = outpad;
        pad_in    = pin;
        model_edge(en, addr, din, com, clr, pin);
        exp_q.push_back(model_outputs(outpad));
    endtask

    // Sample after the coming edge, after the monitor has run.
    task automatic checkOutput(input string name, input logic [31:0] act_sel, input logic [31:0] expv);
        @(posedge prog_clk);
        #2;
        case (act_sel)
            0: check(name, pad_oe, expv);
            1: check(name, cfg_dirty, expv);
            2: check(name, addr_err, expv);
            3: check(name, io_inpad[0], expv);
`ifdef GRID_IO_READBACK_EN
            4: check(name, {rd_valid, rd_data}, expv);
`endif
            default: check(name, 32'hdead, expv);
        endcase
    endtask

    // Async reset mid-cycle with a write+commit pending; outputs must clear at once.
    task automatic doReset();
        @(negedge prog_clk);
        enable  = 1'b1;
        address = 3'd1;
        data_in = 2'b11;
        commit  = 1'b1;
        #2;
        pReset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_pad_oe", pad_oe, 0);
        check("async_rst_io_inpad", io_inpad, 0);
        check("async_rst_dirty", cfg_dirty, 0);
        exp_q.push_back(model_outputs(io_outpad));
        @(negedge prog_clk);
        exp_q.push_back(model_outputs(io_outpad));
    endtask

    // Monitor: compare every queued expectation just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge prog_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pad_oe",    pad_oe,    e.oe);
                check("pad_out",   pad_out,   e.out);
                check("io_inpad",  io_inpad,  e.inpad);
                check("cfg_dirty", cfg_dirty, e.dirty);
                check("addr_err",  addr_err,  e.err);
            end
        end
    end

    initial begin
        model_reset();
        doReset();

        // Write ch3 without commit, then commit.
        applyStimulus(1, 3'd3, 2'b01, 0, 0, 6'h15, 6'h00);
        checkOutput("wr_no_commit_oe", 0, 32'h00);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h2a, 6'h00);
        checkOutput("wr_no_commit_dirty", 1, 1);
        applyStimulus(0, 3'd0, 2'b00, 1, 0, 6'h00, 6'h00);
        checkOutput("commit_oe", 0, 32'h08);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        checkOutput("commit_dirty", 1, 0);

        // Out-of-range writes and the sticky error flag.
        applyStimulus(1, 3'd7, 2'b11, 0, 0, 6'h00, 6'h00);
        checkOutput("illegal_err", 2, 1);
        applyStimulus(1, 3'd6, 2'b01, 0, 1, 6'h00, 6'h00);
        checkOutput("illegal_plus_clr_err", 2, 1);
        applyStimulus(0, 3'd0, 2'b00, 0, 1, 6'h00, 6'h00);
        checkOutput("clr_err_alone", 2, 0);
        applyStimulus(0, 3'd0, 2'b00, 1, 0, 6'h00, 6'h00);
        checkOutput("illegal_no_shadow_change", 0, 32'h08);

        // Reset asserted after a commit.
        doReset();

        // Same-cycle write+commit with another channel pending in shadow.
        applyStimulus(1, 3'd1, 2'b01, 0, 0, 6'h00, 6'h00);
        applyStimulus(1, 3'd5, 2'b01, 1, 0, 6'h00, 6'h00);
        checkOutput("bypass_oe", 0, 32'h22);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        checkOutput("bypass_dirty", 1, 0);

        // Input inversion through the synchroniser, then forced low when driving.
        applyStimulus(1, 3'd0, 2'b10, 1, 0, 6'h00, 6'h00);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        checkOutput("inv_idle", 3, 1);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h01);
        checkOutput("inv_lat1", 3, 1);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h01);
        checkOutput("inv_lat2", 3, 0);
        applyStimulus(1, 3'd0, 2'b11, 1, 0, 6'h00, 6'h00);
        checkOutput("oe_forces_zero", 3, 0);

`ifdef GRID_IO_READBACK_EN
        applyStimulus(1, 3'd2, 2'b11, 0, 0, 6'h00, 6'h00);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        rd_en = 1'b1; rd_addr = 3'd2; rd_sel = 1'b0;
        checkOutput("rd_shadow", 4, 32'h7);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        rd_sel = 1'b1;
        checkOutput("rd_active_precommit", 4, 32'h4);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        rd_addr = 3'd7; rd_sel = 1'b0;
        checkOutput("rd_out_of_range", 4, 32'h4);
        applyStimulus(0, 3'd0, 2'b00, 0, 0, 6'h00, 6'h00);
        rd_en = 1'b0;
        checkOutput("rd_idle", 4, 32'h0);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 1) == 1),
                          3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0),
                          6'($urandom),
                          6'($urandom));
            if (n == 200) doReset();
        end

        repeat (3) @(posedge prog_clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/grid_io_cfg_bank.md
GRID_IO_CFG_BANK -- requirements
Module: grid_io_cfg_bank

Interface
REQ-001 SHALL have parameter NUM_IO, default 8, range 1..64: number of IO channels.
REQ-002 SHALL have parameter CFG_W, default 2, range 1..4: configuration bits per channel.
REQ-003 SHALL have derived localparam ADDR_W = max(1, clog2(NUM_IO)).
REQ-004 SHALL have the following ports; one clock; reset is asynchronous and active-low:
- prog_clk  in  1  configuration and sampling clock
- pReset_n  in  1  asynchronous active-low reset
- enable  in  1  configuration write strobe
- address  in  ADDR_W  target channel
- data_in  in  CFG_W  configuration word
- commit  in  1  copy shadow config to active config
- clr_err  in  1  clear addr_err
- io_outpad  in  NUM_IO  fabric-to-pad data
- pad_in  in  NUM_IO  pad-to-fabric raw data
- pad_out  out  NUM_IO  pad drive data
- pad_oe  out  NUM_IO  pad output enable
- io_inpad  out  NUM_IO  synchronised pad data to fabric
- cfg_dirty  out  1  shadow written since last commit
- addr_err  out  1  sticky out-of-range write flag

Function
REQ-005 SHALL hold two register banks per channel: shadow[i] and active[i], each CFG_W bits.
REQ-006 SHALL accept a write when enable=1 and address<NUM_IO: shadow[address] <= data_in on the next prog_clk rising edge.
REQ-007 SHALL ignore a write with address>=NUM_IO (no shadow change) and set addr_err=1 on the next edge.
REQ-008 SHALL hold addr_err until clr_err=1; if an illegal write and clr_err occur in the same cycle, addr_err SHALL be 1.
REQ-009 SHALL, on commit=1, set active[i] <= shadow[i] for all i at the next edge; the new values are visible on outputs that edge.
REQ-010 SHALL, if a legal write and commit occur in the same cycle, load active[address] with data_in (write bypass); all other channels load shadow.
REQ-011 SHALL set cfg_dirty=1 after any accepted write and clear it after commit; a same-cycle write and commit SHALL leave cfg_dirty=0.
REQ-012 SHALL drive pad_oe[i] = active[i][0] and pad_out[i] = io_outpad[i] combinationally.
REQ-013 SHALL pass pad_in through a 2-flop synchroniser per channel: io_inpad[i] follows pad_in[i] with 2-cycle latency.
REQ-014 SHALL, when CFG_W>=2, invert io_inpad[i] if active[i][1]=1; the inversion applies after the synchroniser, with no added latency.
REQ-015 SHALL force io_inpad[i]=0 while pad_oe[i]=1; loopback is not passed to the fabric.
REQ-016 SHALL leave bits active[i][CFG_W-1:2] as reserved storage, writable and readable, with no effect on function.

Reset
REQ-017 SHALL, on pReset_n=0, asynchronously clear shadow, active, synchroniser flops, cfg_dirty and addr_err.
REQ-018 SHALL therefore reset with pad_oe=0 (all inputs) and io_inpad=0.
REQ-019 SHALL discard a write or commit pending at reset assertion; the first edge after deassertion SHALL operate normally.

Configuration
REQ-020 SHALL, with macro GRID_IO_READBACK_EN defined, add ports rd_en (in, 1), rd_addr (in, ADDR_W), rd_sel (in, 1: 0=shadow, 1=active), rd_data (out, CFG_W) and rd_valid (out, 1).
REQ-021 SHALL, with GRID_IO_READBACK_EN, register rd_data and rd_valid one cycle after rd_en; rd_data SHALL read 0 for out-of-range rd_addr, with rd_valid=1.
REQ-022 SHALL, with GRID_IO_READBACK_EN, return pre-edge contents on a same-cycle read and write to the same channel.
REQ-023 SHALL, without GRID_IO_READBACK_EN, not contain these ports or their logic.

Verification
REQ-024 Reset then write ch3=2'b01, no commit -> pad_oe=0x00, cfg_dirty=1; commit -> pad_oe=0x08, cfg_dirty=0.
REQ-025 With NUM_IO=6, write address 7 -> addr_err=1, no shadow change; illegal write plus clr_err in the same cycle -> addr_err stays 1; clr_err alone -> 0.
REQ-026 With ch0 active=2'b10, toggle pad_in[0] 0->1 -> io_inpad[0] goes 1->0 exactly 2 cycles later; with ch0=2'b11 -> io_inpad[0]=0.
REQ-027 Write ch5=2'b01 with commit in the same cycle, shadow ch1=2'b01 pending -> pad_oe=0x22, cfg_dirty=0.
REQ-028 Assert pReset_n low mid-sequence after a commit -> pad_oe=0, io_inpad=0 immediately, without waiting for a clock edge.
REQ-029 With GRID_IO_READBACK_EN, write ch2=2'b11, then rd_en with rd_addr=2, rd_sel=0 -> rd_data=2'b11 with rd_valid one cycle later; with rd_sel=1 before commit -> rd_data=2'b00.
